atomic_counter_reader: RTL and testbench
========================================

Name: atomic_counter_reader

Overview:
Initiator side of the atomic-counter read bus. On a host request or a periodic tick, it issues a two-phase atomic read (LSB with snapshot, then MSB) over the DATABUS-wide req/atomic/ack interface. It reassembles the COUNTLEN-bit value and presents it with a one-cycle valid pulse. It sits between the counter block and software-facing status logic.

Parameters:
DATABUS, 32, width of count_i bus word
COUNTLEN, 64, width of reassembled value; must equal 2*DATABUS
ACK_TIMEOUT, 16, max cycles waited for ack_i per phase before abort (>=2)
PERIOD_W, 16, width of period_i

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start_i  in  1  single-cycle host read request
periodic_en_i  in  1  enable autonomous periodic reads
period_i  in  PERIOD_W  periodic interval in cycles; 0 treated as disabled
req_o  out  1  bus request, single-cycle pulse per phase
atomic_o  out  1  qualifies req_o: 1 = LSB+snapshot phase, 0 = MSB phase
ack_i  in  1  responder acknowledge; count_i valid in same cycle
count_i  in  DATABUS  responder data word
busy_o  out  1  transaction in flight (state != IDLE)
value_o  out  COUNTLEN  last successfully read value, held between reads
valid_o  out  1  one-cycle pulse when value_o updates
timeout_o  out  1  one-cycle pulse on aborted transaction

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE; req_o=0, atomic_o=0, busy_o=0, valid_o=0, timeout_o=0, value_o=0, lsb holding register=0, period counter=0, pending=0.
- Clock domain: clk only. All outputs are registered.
- FSM states: IDLE, REQ_LSB, WAIT_LSB, REQ_MSB, WAIT_MSB, DONE.
  - IDLE -> REQ_LSB on trigger (start_i, or pending flag).
  - REQ_LSB: req_o=1, atomic_o=1 for exactly 1 cycle -> WAIT_LSB.
  - WAIT_LSB: on ack_i, capture count_i into lsb register -> REQ_MSB.
  - REQ_MSB: req_o=1, atomic_o=0 for 1 cycle -> WAIT_MSB.
  - WAIT_MSB: on ack_i, set value_o={count_i, lsb} -> DONE.
  - DONE: valid_o=1 for 1 cycle -> IDLE.
- Latency: with a responder acking 1 cycle after req, start_i at cycle N gives valid_o at cycle N+5. Minimum start-to-start spacing is 6 cycles.
- Only one request is outstanding at a time; req_o never asserts while in a WAIT state.
- Timeout: a per-phase wait counter resets on entry to each WAIT state. If it reaches ACK_TIMEOUT without ack_i, pulse timeout_o, go to IDLE, and leave value_o unchanged. No MSB request follows a failed LSB phase.
- ack_i in IDLE, REQ_*, or DONE: ignored. Data is not captured.
- start_i while busy_o=1: sets pending; that read starts on the next IDLE. A second start_i while pending is already set is dropped.
- Periodic mode (periodic_en_i=1 and period_i!=0): free-running counter counts 0..period_i-1; on wrap it sets pending. A wrap while pending is already set is merged. Deasserting periodic_en_i clears the counter but not pending.
- Simultaneous start_i and periodic wrap produce a single read.
- Reset asserted mid-transaction aborts immediately. No valid_o or timeout_o is generated.

Optional Feature:
ATOMIC_READER_DELTA_EN
- With it: adds output delta_o [COUNTLEN], registered alongside value_o.
  - delta_o = new value - previous value, modulo 2^COUNTLEN; wrap-around is naturally handled.
  - First read after reset gives delta_o = value_o.
  - Updates only with valid_o.
- Without it: no delta_o port and no subtractor.

Decomposition:
- Package atomic_counter_pkg holds:
  - reader_state_e enum (IDLE..DONE)
  - DATABUS/COUNTLEN default constants
  - ACK_TIMEOUT default
- Sub-module cycle_timer (load/enable/expire down-counter) is instanced twice: ack timeout and period generator.

Test Plan:
- 1-cycle-ack responder holding count 64'h0000_0001_FFFF_FFFE; start_i at cycle 10 -> req/atomic at 11, req/!atomic at 13, valid_o at 15, value_o=64'h0000_0001_FFFF_FFFE.
- Responder increments between phases (snapshot semantics): LSB ack 32'hFFFF_FFFF, MSB ack returns snapshot 32'h0000_0002 -> value_o=64'h0000_0002_FFFF_FFFF.
- Responder never acks LSB, ACK_TIMEOUT=16 -> timeout_o pulses 16 cycles after WAIT_LSB entry, no MSB req, value_o unchanged, busy_o=0.
- periodic_en_i=1, period_i=20, run 200 cycles -> exactly 10 valid_o pulses; start_i mid-read -> one extra read, no lost pulse.
- reset asserted during WAIT_MSB -> all outputs 0 asynchronously; stray ack_i afterwards -> no valid_o.
- DELTA_EN: reads 64'd100 then 64'd1_000_100 -> delta_o=64'd100 then 64'd1_000_000.

Source files
------------

// File: rtl/atomic_counter_pkg.sv
// -----------------------------------------------------------------------------
// atomic_counter_pkg
// Shared types and default sizing for the atomic-counter read bus.
//   reader_state_e  : initiator FSM states
//   *_DEF           : default widths / timeout used as top-level parameter defaults
// -----------------------------------------------------------------------------
package atomic_counter_pkg;

    localparam int DATABUS_DEF     = 32;
    localparam int COUNTLEN_DEF    = 64;
    localparam int ACK_TIMEOUT_DEF = 16;
    localparam int PERIOD_W_DEF    = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ_LSB  = 3'd1,
        WAIT_LSB = 3'd2,
        REQ_MSB  = 3'd3,
        WAIT_MSB = 3'd4,
        DONE     = 3'd5
    } reader_state_e;

endpackage

// File: rtl/cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
// Loadable down-counter that flags expiry when it is enabled at zero, then
// reloads itself so it can also serve as a free-running period generator.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   i_load       : force counter to i_load_val (has priority over i_en)
//   i_load_val   : reload / start value (expiry after i_load_val+1 enabled cycles)
//   i_en         : count down one step per cycle
//   o_expire     : high in the enabled cycle in which the counter is zero
// -----------------------------------------------------------------------------
module cycle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expire
);

    logic [W-1:0] r_count;
    logic         w_zero;

    assign w_zero   = (r_count == '0);
    assign o_expire = i_en && !i_load && w_zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= w_zero ? i_load_val : (r_count - 1'b1);
        end
    end

endmodule

// File: rtl/atomic_counter_reader.sv
// -----------------------------------------------------------------------------
// atomic_counter_reader
// Initiator of the two-phase atomic counter read: an LSB phase that also makes
// the responder snapshot its MSB, followed by an MSB phase. The reassembled
// value is presented on value_o with a one-cycle valid_o pulse.
// Build option: define ATOMIC_READER_DELTA_EN to add delta_o, the modular
// difference between the new and the previous value_o.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   start_i        : single-cycle host read request (queued once if busy)
//   periodic_en_i  : enable autonomous reads every period_i cycles
//   period_i       : read interval in cycles, 0 = periodic reads disabled
//   req_o/atomic_o : one-cycle bus request; atomic_o=1 LSB+snapshot, 0 MSB
//   ack_i/count_i  : responder acknowledge with data word in the same cycle
//   busy_o         : transaction in flight
//   value_o        : last successfully read value
//   valid_o        : one-cycle pulse when value_o updates
//   timeout_o      : one-cycle pulse when a phase got no ack in time
//   delta_o        : (ATOMIC_READER_DELTA_EN only) value_o minus previous value
// -----------------------------------------------------------------------------
module atomic_counter_reader
    import atomic_counter_pkg::*;
#(
    parameter int DATABUS     = DATABUS_DEF,
    parameter int COUNTLEN    = COUNTLEN_DEF,   // must be 2*DATABUS
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF, // >= 2
    parameter int PERIOD_W    = PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic                periodic_en_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                req_o,
    output logic                atomic_o,
    input  logic                ack_i,
    input  logic [DATABUS-1:0]  count_i,
    output logic                busy_o,
    output logic [COUNTLEN-1:0] value_o,
    output logic                valid_o,
    output logic                timeout_o
`ifdef ATOMIC_READER_DELTA_EN
    ,
    output logic [COUNTLEN-1:0] delta_o
`endif
);

    localparam int              TO_W    = $clog2(ACK_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(ACK_TIMEOUT - 1);

    reader_state_e        r_state, w_next;
    logic                 r_pending;
    logic [DATABUS-1:0]   r_lsb;
    logic [COUNTLEN-1:0]  r_value;
    logic                 r_req, r_atomic, r_busy, r_valid, r_timeout;
    logic                 w_wait, w_to_expire, w_per_active, w_wrap, w_abort;
    logic [COUNTLEN-1:0]  w_new_value;

    assign w_wait       = (r_state == WAIT_LSB) || (r_state == WAIT_MSB);
    assign w_per_active = periodic_en_i && (period_i != '0);
    assign w_new_value  = {count_i, r_lsb};

    // Held loaded outside the WAIT states, so every WAIT entry starts a fresh
    // ACK_TIMEOUT-cycle window; expiry lands on the last cycle of the window.
    cycle_timer #(.W(TO_W)) u_ack_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (!w_wait),
        .i_load_val (TO_LOAD),
        .i_en       (w_wait),
        .o_expire   (w_to_expire)
    );

    // Counting down from period_i-1 is the mirror of counting 0..period_i-1;
    // holding it loaded while disabled is the "cleared" state.
    cycle_timer #(.W(PERIOD_W)) u_period_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (!w_per_active),
        .i_load_val (period_i - 1'b1),
        .i_en       (w_per_active),
        .o_expire   (w_wrap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            IDLE:     if (start_i || r_pending || w_wrap) w_next = REQ_LSB;
            REQ_LSB:  w_next = WAIT_LSB;
            WAIT_LSB: begin
                if (ack_i) begin
                    w_next = REQ_MSB;
                end else if (w_to_expire) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end
            end
            REQ_MSB:  w_next = WAIT_MSB;
            WAIT_MSB: begin
                if (ack_i) begin
                    w_next = DONE;
                end else if (w_to_expire) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end
            end
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Any trigger seen in IDLE launches the read directly, so pending only
    // collects requests that arrive mid-transaction; extra ones merge into it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 r_pending <= 1'b0;
        else if (r_state == IDLE)   r_pending <= 1'b0;
        else if (start_i || w_wrap) r_pending <= 1'b1;
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req     <= 1'b0;
            r_atomic  <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_lsb     <= '0;
            r_value   <= '0;
        end else begin
            r_req     <= (w_next == REQ_LSB) || (w_next == REQ_MSB);
            r_atomic  <= (w_next == REQ_LSB);
            r_busy    <= (w_next != IDLE);
            r_valid   <= (w_next == DONE);
            r_timeout <= w_abort;
            if (r_state == WAIT_LSB && ack_i) r_lsb   <= count_i;
            if (r_state == WAIT_MSB && ack_i) r_value <= w_new_value;
        end
    end

`ifdef ATOMIC_READER_DELTA_EN
    logic [COUNTLEN-1:0] r_delta;

    // r_value is 0 out of reset, so the first delta equals the first value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            r_delta <= '0;
        else if (r_state == WAIT_MSB && ack_i) r_delta <= w_new_value - r_value;
    end

    assign delta_o = r_delta;
`endif

    assign req_o     = r_req;
    assign atomic_o  = r_atomic;
    assign busy_o    = r_busy;
    assign valid_o   = r_valid;
    assign timeout_o = r_timeout;
    assign value_o   = r_value;

endmodule

// File: tb/tb_atomic_counter_reader.sv
module tb_atomic_counter_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i, periodic_en_i;
    logic [15:0] period_i;
    logic        req_o, atomic_o, ack_i;
    logic [31:0] count_i;
    logic        busy_o, valid_o, timeout_o;
    logic [63:0] value_o;
`ifdef ATOMIC_READER_DELTA_EN
    logic [63:0] delta_o;
`endif

    atomic_counter_reader dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .periodic_en_i (periodic_en_i),
        .period_i      (period_i),
        .req_o         (req_o),
        .atomic_o      (atomic_o),
        .ack_i         (ack_i),
        .count_i       (count_i),
        .busy_o        (busy_o),
        .value_o       (value_o),
        .valid_o       (valid_o),
        .timeout_o     (timeout_o)
`ifdef ATOMIC_READER_DELTA_EN
        ,
        .delta_o       (delta_o)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_valid = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    endtask

    // responder: acks one cycle after each req_o, data chosen by the phase
    logic [31:0] lsb_word = '0, msb_word = '0;
    logic        ack_en = 1'b1, stray = 1'b0;
    logic        pend_ack;
    logic [31:0] pend_data;

    initial begin
        ack_i = 1'b0; count_i = '0; pend_ack = 1'b0; pend_data = '0;
        forever begin
            @(posedge clk); #1;
            ack_i     = pend_ack | stray;
            count_i   = pend_data;
            pend_ack  = req_o & ack_en;
            pend_data = atomic_o ? lsb_word : msb_word;
        end
    end

    // scoreboard monitor
    logic [63:0] sb[$];
    logic [63:0] model_prev = '0;

    always @(negedge clk) begin
        if (valid_o) begin
            logic [63:0] e;
            n_valid++;
            chk("sb_avail", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("value", value_o, e);
`ifdef ATOMIC_READER_DELTA_EN
                chk("delta", delta_o, e - model_prev);
`endif
                model_prev = e;
            end
        end
    end

    task automatic do_read(input logic [31:0] lo, input logic [31:0] hi);
        lsb_word = lo; msb_word = hi;
        sb.push_back({hi, lo});
        start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int v0, seen_k;
        logic saw_msb;
        reset = 1'b0; start_i = 1'b0; periodic_en_i = 1'b0; period_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_req",   64'(req_o),     64'd0);
        chk("rst_busy",  64'(busy_o),    64'd0);
        chk("rst_valid", 64'(valid_o),   64'd0);
        chk("rst_to",    64'(timeout_o), 64'd0);
        chk("rst_value", value_o,        64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // cycle-accurate read: start in cycle 10 -> req 11, MSB req 13, valid 15
        lsb_word = 32'hFFFF_FFFE; msb_word = 32'h0000_0001;
        sb.push_back(64'h0000_0001_FFFF_FFFE);
        start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        chk("c11_req", 64'({req_o, atomic_o, busy_o}), 64'b111);
        @(negedge clk);
        chk("c12_req", 64'({req_o, busy_o}), 64'b01);
        @(negedge clk);
        chk("c13_req", 64'({req_o, atomic_o}), 64'b10);
        @(negedge clk);
        chk("c14_req", 64'(req_o), 64'd0);
        @(negedge clk);
        chk("c15_valid", 64'(valid_o), 64'd1);
        @(negedge clk);
        chk("c16_idle", 64'({valid_o, busy_o}), 64'b00);
        repeat (3) @(negedge clk);

        // snapshot semantics
        do_read(32'hFFFF_FFFF, 32'h0000_0002);

        // LSB never acked -> timeout 18 cycles after start cycle, no MSB req
        ack_en = 1'b0; v0 = n_valid; seen_k = 0; saw_msb = 1'b0;
        start_i = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (req_o && !atomic_o) saw_msb = 1'b1;
            if (timeout_o) begin seen_k = k; break; end
        end
        chk("to_cycle",  64'(seen_k), 64'd18);
        chk("to_busy",   64'(busy_o), 64'd0);
        chk("to_value",  value_o, 64'h0000_0002_FFFF_FFFF);
        chk("to_no_msb", 64'(saw_msb), 64'd0);
        @(negedge clk);
        chk("to_pulse",  64'(timeout_o), 64'd0);
        chk("to_novalid", 64'(n_valid - v0), 64'd0);
        ack_en = 1'b1;

        // periodic reads every 20 cycles for 200 cycles, plus one host read mid-read
        lsb_word = 32'h0000_0005; msb_word = 32'h0000_0007;
        for (int i = 0; i < 11; i++) sb.push_back(64'h0000_0007_0000_0005);
        v0 = n_valid;
        period_i = 16'd20;
        @(negedge clk);
        periodic_en_i = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            start_i = (i == 23);
        end
        periodic_en_i = 1'b0;
        repeat (30) @(negedge clk);
        chk("per_count", 64'(n_valid - v0), 64'd11);
        chk("per_sb",    64'(sb.size()),    64'd0);

        // reset during WAIT_MSB aborts immediately; stray ack afterwards ignored
        lsb_word = 32'h1234_5678; msb_word = 32'h9ABC_DEF0;
        v0 = n_valid;
        start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0; model_prev = '0;
        #1;
        chk("ra_out",   64'({req_o, atomic_o, busy_o, valid_o, timeout_o}), 64'd0);
        chk("ra_value", value_o, 64'd0);
`ifdef ATOMIC_READER_DELTA_EN
        chk("ra_delta", delta_o, 64'd0);
`endif
        @(negedge clk);
        reset = 1'b1; stray = 1'b1;
        repeat (2) @(negedge clk);
        stray = 1'b0;
        repeat (8) @(negedge clk);
        chk("ra_novalid", 64'(n_valid - v0), 64'd0);
        chk("ra_busy",    64'(busy_o), 64'd0);

        // delta sequence (delta checked by the monitor when enabled)
        do_read(32'd100, 32'd0);
        do_read(32'd1_000_100, 32'd0);
        chk("end_value", value_o, 64'd1_000_100);
        chk("end_sb",    64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
